// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI channel arbiter.
// Imported by the arbiter top level and by its byte shifter.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    OWN   = 2'd2,
    SHIFT = 2'd3
  } state_e;

  localparam int REQ_HOST           = 0;
  localparam int REQ_GUEST          = 1;
  localparam int DIV_W              = 8;
  localparam int DEFAULT_DIV_FAST   = 1;
  localparam int DEFAULT_DIV_SLOW   = 62;
  localparam int DEFAULT_GAP_CYCLES = 16;

  function automatic logic [1:0] req_onehot(input logic idx);
    return (idx == 1'(REQ_GUEST)) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 byte engine, MSB first: drives SCK/MOSI, samples MISO on rising SCK.
// done is high in the cycle whose closing edge produces the eighth falling SCK edge.
module sd_spi_shifter
  import sd_spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       tx_byte,
  input  logic [DIV_W-1:0] divider,
  input  logic             miso,
  output logic             sck,
  output logic             mosi,
  output logic             done,
  output logic [7:0]       rx_byte
);

  logic             busy_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       tx_sh_r;
  logic [7:0]       rx_sh_r;

  assign done    = busy_r && (cnt_r == div_r) && sck && (bit_cnt_r == 3'd7);
  assign rx_byte = rx_sh_r;

  // Half-period timing, SCK toggling and the MOSI/MISO shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      div_r     <= {DIV_W{1'b0}};
      cnt_r     <= {DIV_W{1'b0}};
      bit_cnt_r <= 3'd0;
      tx_sh_r   <= 8'hFF;
      rx_sh_r   <= 8'h00;
      sck       <= 1'b0;
      mosi      <= 1'b1;
    end else if (start) begin
      busy_r    <= 1'b1;
      div_r     <= divider;
      cnt_r     <= {DIV_W{1'b0}};
      bit_cnt_r <= 3'd0;
      tx_sh_r   <= {tx_byte[6:0], 1'b1};
      sck       <= 1'b0;
      mosi      <= tx_byte[7];
    end else if (busy_r) begin
      if (cnt_r == div_r) begin
        cnt_r <= {DIV_W{1'b0}};
        sck   <= ~sck;
        if (!sck) begin
          rx_sh_r <= {rx_sh_r[6:0], miso};
        end else if (bit_cnt_r == 3'd7) begin
          // Last falling edge: release the line to its idle-high level.
          busy_r <= 1'b0;
          mosi   <= 1'b1;
        end else begin
          mosi      <= tx_sh_r[7];
          tx_sh_r   <= {tx_sh_r[6:0], 1'b1};
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
      end else begin
        cnt_r <= cnt_r + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/sd_spi_arbiter.sv
// Round-robin owner of the shared SD SPI channel: grants one requester at a time,
// drives chip-select with a CS-high gap on owner change, and runs its byte transfers.
module sd_spi_arbiter
  import sd_spi_pkg::*;
#(
  parameter int DIV_FAST   = DEFAULT_DIV_FAST,
  parameter int DIV_SLOW   = DEFAULT_DIV_SLOW,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  slow,
  input  logic [1:0]  tx_valid,
  input  logic [15:0] tx_data,
  output logic [1:0]  tx_ready,
  output logic [1:0]  rx_valid,
  output logic [7:0]  rx_data,
  output logic        sd_cs_n,
  output logic        sd_sck,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

  state_e           state_r;
  logic             owner_r;
  logic             last_r;
  logic             have_last_r;
  logic [GAP_W-1:0] gap_cnt_r;

  logic             winner_s;
  logic             start_s;
  logic [7:0]       tx_byte_s;
  logic [DIV_W-1:0] div_s;
  logic             done_s;
  logic [7:0]       rx_byte_s;

  // Winner selection, byte acceptance and the owner's byte/divider selection.
  always_comb begin
    winner_s = 1'b0;
    if (req == 2'b11) begin
      winner_s = ~last_r;
    end else if (req[1]) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    start_s   = (state_r == OWN) && tx_valid[owner_r] && tx_ready[owner_r];
    tx_byte_s = tx_data[{owner_r, 3'b000} +: 8];
    if (slow[owner_r]) begin
      div_s = DIV_W'(DIV_SLOW);
    end else begin
      div_s = DIV_W'(DIV_FAST);
    end
  end

  sd_spi_shifter u_shifter (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .start   (start_s),
    .tx_byte (tx_byte_s),
    .divider (div_s),
    .miso    (sd_miso),
    .sck     (sd_sck),
    .mosi    (sd_mosi),
    .done    (done_s),
    .rx_byte (rx_byte_s)
  );

  // Ownership FSM with registered grant, handshake and chip-select outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;
      have_last_r <= 1'b0;
      gap_cnt_r   <= {GAP_W{1'b0}};
      gnt         <= 2'b00;
      tx_ready    <= 2'b00;
      rx_valid    <= 2'b00;
      rx_data     <= 8'h00;
      sd_cs_n     <= 1'b1;
    end else begin
      rx_valid <= 2'b00;
      case (state_r)
        IDLE: begin
          if (req != 2'b00) begin
            owner_r     <= winner_s;
            last_r      <= winner_s;
            have_last_r <= 1'b1;
            gnt         <= req_onehot(winner_s);
            // Same card session can resume without a CS-high gap.
            if (have_last_r && (winner_s == last_r)) begin
              state_r  <= OWN;
              sd_cs_n  <= 1'b0;
              tx_ready <= req_onehot(winner_s);
            end else begin
              state_r   <= GAP;
              gap_cnt_r <= {GAP_W{1'b0}};
            end
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
            state_r  <= OWN;
            sd_cs_n  <= 1'b0;
            tx_ready <= req_onehot(owner_r);
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        OWN: begin
          if (start_s) begin
            state_r  <= SHIFT;
            tx_ready <= 2'b00;
          end else if (!req[owner_r]) begin
            state_r  <= IDLE;
            gnt      <= 2'b00;
            tx_ready <= 2'b00;
            sd_cs_n  <= 1'b1;
          end
        end
        SHIFT: begin
          if (done_s) begin
            state_r  <= OWN;
            rx_valid <= req_onehot(owner_r);
            rx_data  <= rx_byte_s;
            tx_ready <= req_onehot(owner_r);
          end
        end
        default: begin
          state_r  <= IDLE;
          gnt      <= 2'b00;
          tx_ready <= 2'b00;
          sd_cs_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Directed self-checking bench for sd_spi_arbiter with default parameters
// (fast half-period 2 cycles, slow half-period 63 cycles, 16-cycle CS gap).
module tb_sd_spi_arbiter;

  logic        CLOCK_50;
  logic        RESET_N;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  slow;
  logic [1:0]  tx_valid;
  logic [15:0] tx_data;
  logic [1:0]  tx_ready;
  logic [1:0]  rx_valid;
  logic [7:0]  rx_data;
  logic        sd_cs_n;
  logic        sd_sck;
  logic        sd_mosi;
  logic        sd_miso;

  logic        loop_en;
  logic        miso_fix;
  int          checks;
  int          errors;

  assign sd_miso = loop_en ? sd_mosi : miso_fix;

  sd_spi_arbiter dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .req      (req),
    .gnt      (gnt),
    .slow     (slow),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .sd_cs_n  (sd_cs_n),
    .sd_sck   (sd_sck),
    .sd_mosi  (sd_mosi),
    .sd_miso  (sd_miso)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte while the owner is in OWN, then run ncyc cycles watching the bus.
  task automatic xfer(input int who, input logic [7:0] b, input int ncyc, input int drop_at,
                      output logic [7:0] seq, output int rises, output int early_rx,
                      output int cs_bad);
    logic prev;
    tx_data[who*8 +: 8] = b;
    tx_valid[who] = 1'b1;
    tick();
    tx_valid = 2'b00;
    seq = 8'h00; rises = 0; early_rx = 0; cs_bad = 0; prev = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == drop_at) begin
        req[who]  = 1'b0;
        slow[who] = 1'b1;
      end
      tick();
      if (sd_sck && !prev) begin
        seq = {seq[6:0], sd_mosi};
        rises++;
      end
      prev = sd_sck;
      if (k < ncyc && rx_valid != 2'b00) early_rx++;
      if (sd_cs_n !== 1'b0) cs_bad++;
    end
  endtask

  // Walk through a 16-cycle gap and return the number of gap cycles that misbehaved.
  task automatic gap_walk(input logic [1:0] g, output int bad);
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (sd_cs_n !== 1'b1 || tx_ready !== 2'b00 || gnt !== g) bad++;
    end
    tick();
  endtask

  initial begin
    logic [7:0] seq;
    int rises, early, csb, bad, cyc, n, cnt;
    int acc [3];

    checks = 0; errors = 0;
    RESET_N = 1'b0; req = 2'b00; slow = 2'b00; tx_valid = 2'b00; tx_data = 16'h0000;
    loop_en = 1'b0; miso_fix = 1'b1;
    repeat (3) tick();
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_tx_ready", tx_ready, 2'b00);
    chk("reset_rx_valid", rx_valid, 2'b00);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_cs_n", sd_cs_n, 1'b1);
    chk("reset_sck", sd_sck, 1'b0);
    chk("reset_mosi", sd_mosi, 1'b1);
    RESET_N = 1'b1;
    tick();
    chk("idle_cs_n", sd_cs_n, 1'b1);

    // Simultaneous requests after reset: host wins, gap first.
    req = 2'b11;
    tick();
    chk("gap_entry_gnt", gnt, 2'b01);
    chk("gap_entry_cs_n", sd_cs_n, 1'b1);
    chk("gap_entry_tx_ready", tx_ready, 2'b00);
    gap_walk(2'b01, bad);
    chk("gap_cycles_bad", bad, 0);
    chk("own_cs_n", sd_cs_n, 1'b0);
    chk("own_tx_ready", tx_ready, 2'b01);
    chk("own_gnt", gnt, 2'b01);

    // Single fast byte 0xA5 with MISO looped back.
    loop_en = 1'b1;
    xfer(0, 8'hA5, 32, 0, seq, rises, early, csb);
    chk("fast_mosi_seq", seq, 8'hA5);
    chk("fast_sck_pulses", rises, 8);
    chk("fast_early_rx", early, 0);
    chk("fast_cs_low", csb, 0);
    chk("fast_rx_valid", rx_valid, 2'b01);
    chk("fast_rx_data", rx_data, 8'hA5);
    chk("fast_tx_ready_back", tx_ready, 2'b01);
    tick();
    chk("fast_rx_pulse_width", rx_valid, 2'b00);

    // Back-to-back bytes: acceptance every 33 cycles with CS held low.
    tx_data[7:0] = 8'h5A;
    tx_valid = 2'b01;
    cyc = 0; n = 0; csb = 0;
    while (n < 3 && cyc < 150) begin
      if (tx_ready[0]) begin
        acc[n] = cyc;
        n++;
      end
      tick();
      cyc++;
      if (n == 3) tx_valid = 2'b00;
      if (sd_cs_n !== 1'b0) csb++;
    end
    chk("b2b_accepts", n, 3);
    chk("b2b_gap_1", acc[1] - acc[0], 33);
    chk("b2b_gap_2", acc[2] - acc[1], 33);
    chk("b2b_cs_low", csb, 0);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (rx_valid == 2'b00 && cnt < 40);
    chk("b2b_last_latency", cnt, 32);
    chk("b2b_rx_data", rx_data, 8'h5A);

    // Host releases; waiting guest gets the bus after a gap.
    req[0] = 1'b0;
    tick();
    chk("release_gnt", gnt, 2'b00);
    chk("release_cs_n", sd_cs_n, 1'b1);
    tick();
    chk("guest_gap_gnt", gnt, 2'b10);
    gap_walk(2'b10, bad);
    chk("guest_gap_bad", bad, 0);
    chk("guest_own_cs_n", sd_cs_n, 1'b0);
    chk("guest_tx_ready", tx_ready, 2'b10);

    // Slow byte, MISO held high.
    slow = 2'b10; loop_en = 1'b0; miso_fix = 1'b1;
    xfer(1, 8'hC3, 1008, 0, seq, rises, early, csb);
    chk("slow_mosi_seq", seq, 8'hC3);
    chk("slow_sck_pulses", rises, 8);
    chk("slow_early_rx", early, 0);
    chk("slow_rx_valid", rx_valid, 2'b10);
    chk("slow_rx_data", rx_data, 8'hFF);
    tick();

    // Guest drops req (and flips slow) mid-byte: byte completes at fast timing.
    slow = 2'b00; loop_en = 1'b1;
    xfer(1, 8'h3C, 32, 14, seq, rises, early, csb);
    chk("drop_sck_pulses", rises, 8);
    chk("drop_early_rx", early, 0);
    chk("drop_rx_valid", rx_valid, 2'b10);
    chk("drop_rx_data", rx_data, 8'h3C);
    chk("drop_gnt_held", gnt, 2'b10);
    tick();
    chk("drop_gnt_clear", gnt, 2'b00);
    chk("drop_cs_n", sd_cs_n, 1'b1);
    chk("drop_tx_ready", tx_ready, 2'b00);

    // Guest was granted last, so a tie goes to the host.
    slow = 2'b00; req = 2'b11;
    tick();
    chk("rr_gnt", gnt, 2'b01);
    gap_walk(2'b01, bad);
    chk("rr_gap_bad", bad, 0);

    // A byte offered by the non-owner is ignored.
    tx_data[15:8] = 8'hFF;
    tx_valid = 2'b10;
    tick();
    tx_valid = 2'b00;
    chk("unowned_tx_ready", tx_ready, 2'b01);
    tick();
    chk("unowned_sck", sd_sck, 1'b0);

    // Same owner re-requests: straight back to OWN without a gap.
    req = 2'b00;
    tick();
    chk("rereq_release_gnt", gnt, 2'b00);
    req = 2'b01;
    tick();
    chk("rereq_cs_n", sd_cs_n, 1'b0);
    chk("rereq_tx_ready", tx_ready, 2'b01);

    // Reset in the middle of a byte.
    tx_data[7:0] = 8'h00;
    tx_valid = 2'b01;
    tick();
    tx_valid = 2'b00;
    repeat (19) tick();
    chk("midbyte_sck_high", sd_sck, 1'b1);
    RESET_N = 1'b0;
    #1;
    chk("async_cs_n", sd_cs_n, 1'b1);
    chk("async_sck", sd_sck, 1'b0);
    chk("async_mosi", sd_mosi, 1'b1);
    chk("async_gnt", gnt, 2'b00);
    chk("async_tx_ready", tx_ready, 2'b00);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rx_valid !== 2'b00) bad++;
    end
    chk("async_no_rx", bad, 0);
    RESET_N = 1'b1;
    tick();
    chk("post_reset_gap_gnt", gnt, 2'b01);
    chk("post_reset_gap_cs_n", sd_cs_n, 1'b1);
    gap_walk(2'b01, bad);
    chk("post_reset_gap_bad", bad, 0);
    chk("post_reset_own_cs_n", sd_cs_n, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_spi_arbiter.md
Name: sd_spi_arbiter

Overview:
- Shares the board's single SD-card SPI channel (CS/SCK/MOSI/MISO) between two requesters: requester 0 is the host-side control path (MCU/data_io firmware loader) and requester 1 is the guest core's SD interface.
- Arbitrates ownership of the channel, drives chip-select, and runs SPI mode-0 byte transfers on behalf of whichever requester currently holds the grant.
- Sits in the board top, between the requesters and the SD pins, replacing the ad-hoc SCK multiplexing.

Parameters:
- DIV_FAST, 1: SCK half-period minus one, in clock cycles, for fast mode (half-period = DIV_FAST+1).
- DIV_SLOW, 62: SCK half-period minus one for slow mode; used for SD init at or below 400 kHz.
- GAP_CYCLES, 16: clock cycles CS is held high between two different owners.

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- req  in  2  per-requester bus request; level, held for the whole transaction.
- gnt  out  2  one-hot grant; at most one bit set.
- slow  in  2  per-requester speed select; 1 selects DIV_SLOW.
- tx_valid  in  2  per-requester byte offer.
- tx_data  in  16  [7:0] is requester 0's byte, [15:8] is requester 1's.
- tx_ready  out  2  byte accepted when tx_valid and tx_ready are both high.
- rx_valid  out  2  one-cycle pulse to the owner when its byte completes.
- rx_data  out  8  received byte; valid while rx_valid is high; shared by both requesters.
- sd_cs_n  out  1  SD chip select, active low.
- sd_sck  out  1  SPI clock.
- sd_mosi  out  1  SPI data out.
- sd_miso  in  1  SPI data in.

Behaviour:
- Clock and reset: one clock, CLOCK_50. RESET_N is asynchronous and active-low.
- Reset values: gnt=0, tx_ready=0, rx_valid=0, rx_data=0, sd_cs_n=1, sd_sck=0, sd_mosi=1. The round-robin pointer resets to favour requester 0.
- State machine: IDLE, GAP, OWN, SHIFT.
- IDLE:
  - No request: stay in IDLE, sd_cs_n=1.
  - Any request: pick a winner round-robin (the requester not granted last wins a tie; after reset, requester 0 wins).
  - Winner equals the last owner and no other owner has held the bus since: go straight to OWN.
  - Otherwise: go to GAP.
- GAP:
  - sd_cs_n=1 for GAP_CYCLES cycles.
  - gnt is asserted on entry to GAP; tx_ready stays 0 throughout GAP.
  - Then go to OWN.
- OWN:
  - sd_cs_n=0, gnt[owner]=1, tx_ready[owner]=1; the other tx_ready bit is 0.
  - tx_valid & tx_ready: latch the byte and the owner's slow bit, go to SHIFT.
  - req[owner] falling with no accepted byte: clear gnt and go to IDLE the next cycle. sd_cs_n returns high in that same cycle.
- SHIFT (sub-module):
  - SPI mode 0, MSB first. SCK idles low.
  - MOSI bit 7 is driven on SHIFT entry. MISO is sampled on each rising SCK edge. The next MOSI bit is driven on each falling edge.
  - Eight SCK pulses take 16*(DIV+1) cycles, where DIV is the latched speed divider.
  - The cycle after the last falling edge: rx_valid[owner]=1 for one cycle, rx_data holds the byte, go to OWN.
  - tx_ready[owner] is reasserted in that same cycle, so back-to-back bytes leave exactly one idle cycle between bytes.
- Slow changes mid-byte are ignored; the latched divider is used until the byte completes.
- req[owner] dropping during SHIFT: the byte still completes and rx_valid still pulses. Then OWN sees req low and releases. A byte is never truncated.
- Non-owner: req from the non-owner is never serviced mid-ownership. Its gnt, tx_ready and rx_valid stay 0, and it is serviced after the owner releases.
- Unowned inputs: tx_valid from a non-granted requester is ignored; no byte is latched.
- Reset mid-byte: all outputs return to their reset values immediately and asynchronously. No rx_valid pulse occurs for the partial byte.

Decomposition:
- Shared package sd_spi_pkg: state enum (IDLE, GAP, OWN, SHIFT), requester index constants REQ_HOST=0 and REQ_GUEST=1, and the default divider constants.
- One sub-module, sd_spi_shifter:
  - Inputs: start, byte, divider, miso.
  - Outputs: sck, mosi, done pulse, rx byte.
  - Holds the half-period counter and the bit counter.
- sd_spi_arbiter holds the arbitration logic, the GAP counter and the handshake logic.

Test Plan:
- Single byte, fast mode: requester 0 requests, sends 0xA5, MISO looped to MOSI.
  -> gnt=01 after GAP_CYCLES=16.
  -> 8 SCK pulses over 32 cycles; MOSI sequence 1,0,1,0,0,1,0,1.
  -> rx_valid[0] pulses once with rx_data=0xA5.
- Simultaneous requests after reset: req=11.
  -> Requester 0 is granted first.
  -> Requester 0 drops req: sd_cs_n goes high, 16 GAP cycles elapse, then gnt=10.
  -> Next simultaneous request goes to requester 0 again, because requester 1 was granted last.
- Slow mode: slow[1]=1 with DIV_SLOW=62 -> each SCK half-period is 63 cycles and the byte takes 1008 cycles; MISO held at 1 -> rx_data=0xFF.
- Release during a byte: requester 1 drops req at bit 3 of byte 0x3C.
  -> All 8 bits complete and rx_valid[1] pulses.
  -> gnt clears the cycle after return to OWN, and sd_cs_n goes high.
- Back-to-back: three consecutive accepted bytes in fast mode -> exactly 33 cycles from acceptance to acceptance, with sd_cs_n continuously low.
- Reset mid-byte: assert RESET_N low during bit 5.
  -> Immediately: sd_cs_n=1, sd_sck=0, sd_mosi=1, gnt=0, and no rx_valid pulse.
  -> After release: a fresh request to requester 0 still passes through GAP.
